// File: rtl/ram_block_reader.sv
// ram_block_reader: drains one DEPTH-word block per block-ready pulse into a registered stream stage.
// Optional per-block XOR checksum enabled by defining RAM_BLOCK_READER_CHECKSUM_EN.
`default_nettype none

module ram_block_reader #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             buf_block_ready_i,
  input  logic [WIDTH-1:0] buf_data_i,
  input  logic             buf_valid_i,
  output logic             buf_ready_o,
  output logic [WIDTH-1:0] m_data_o,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic             m_first_o,
  output logic             m_last_o,
  output logic             busy_o,
  output logic             block_done_o,
  output logic             overrun_o,
  output logic [15:0]      blocks_read_o,
  output logic [WIDTH-1:0] checksum_o
);

  localparam logic [ADDR_WIDTH:0] LAST_IDX = (ADDR_WIDTH+1)'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    TAIL  = 2'd2
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [ADDR_WIDTH:0] count;
  logic                up_xfer;
  logic                dn_xfer;
  logic                last_xfer;
  logic                enter_drain;
  logic                overrun_hit;

  assign buf_ready_o = (state == DRAIN) && (!m_valid_o || m_ready_i);
  assign up_xfer     = buf_valid_i && buf_ready_o;
  assign dn_xfer     = m_valid_o && m_ready_i;
  assign last_xfer   = dn_xfer && m_last_o;
  assign busy_o      = (state != IDLE);

  // A pulse is only honoured when idle or exactly on the final downstream handshake.
  assign overrun_hit = buf_block_ready_i &&
                       ((state == DRAIN) || ((state == TAIL) && !last_xfer));

  always_comb begin
    state_next  = state;
    enter_drain = 1'b0;
    case (state)
      IDLE: begin
        if (buf_block_ready_i) begin
          state_next  = DRAIN;
          enter_drain = 1'b1;
        end
      end
      DRAIN: begin
        if (up_xfer && (count == LAST_IDX)) begin
          state_next = TAIL;
        end
      end
      TAIL: begin
        if (last_xfer) begin
          if (buf_block_ready_i) begin
            state_next  = DRAIN;
            enter_drain = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      if (enter_drain) begin
        count <= '0;
      end else if (up_xfer) begin
        count <= count + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_data_o      <= '0;
      m_valid_o     <= 1'b0;
      m_first_o     <= 1'b0;
      m_last_o      <= 1'b0;
      block_done_o  <= 1'b0;
      overrun_o     <= 1'b0;
      blocks_read_o <= '0;
    end else begin
      if (up_xfer) begin
        m_data_o  <= buf_data_i;
        m_valid_o <= 1'b1;
        m_first_o <= (count == '0);
        m_last_o  <= (count == LAST_IDX);
      end else if (dn_xfer) begin
        m_valid_o <= 1'b0;
        m_first_o <= 1'b0;
        m_last_o  <= 1'b0;
      end
      block_done_o <= last_xfer;
      overrun_o    <= overrun_hit;
      if (last_xfer) begin
        blocks_read_o <= blocks_read_o + 16'd1;
      end
    end
  end

`ifdef RAM_BLOCK_READER_CHECKSUM_EN
  logic [WIDTH-1:0] xor_acc;
  logic [WIDTH-1:0] checksum_q;

  // The last word is fetched before it drains, so xor_acc is complete on last_xfer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      xor_acc    <= '0;
      checksum_q <= '0;
    end else begin
      if (enter_drain) begin
        xor_acc <= '0;
      end else if (up_xfer) begin
        xor_acc <= xor_acc ^ buf_data_i;
      end
      if (last_xfer) begin
        checksum_q <= xor_acc;
      end
    end
  end

  assign checksum_o = checksum_q;
`else
  assign checksum_o = '0;
`endif

endmodule

`default_nettype wire

// File: doc/ram_block_reader.md
# ram_block_reader

Downstream drain engine for the ping-pong block buffer. On each block-ready pulse from the buffer it pulls exactly DEPTH words over the buffer's valid/ready read port and forwards them through a one-deep registered stage to a streaming consumer, tagging the first and last word of each block. It reports block completion and overrun (a new block announced while one is still draining), and optionally computes a per-block checksum.

## Interface
- WIDTH, 32: data word width in bits.
- DEPTH, 256: words per block; must equal the buffer's DEPTH and be at least 2.
- ADDR_WIDTH, $clog2(DEPTH): index width; counters are ADDR_WIDTH+1 bits.
- clk_i  input  1  single clock, rising edge.
- rst_ni  input  1  reset; asynchronous, active-low.
- buf_block_ready_i  input  1  one-cycle pulse: a full block is available.
- buf_data_i  input  WIDTH  read data from the buffer.
- buf_valid_i  input  1  buf_data_i valid.
- buf_ready_o  output  1  reader accepts buf_data_i this cycle.
- m_data_o  output  WIDTH  registered output word.
- m_valid_o  output  1  m_data_o valid.
- m_ready_i  input  1  consumer accepts the word.
- m_first_o  output  1  current word is block index 0.
- m_last_o  output  1  current word is block index DEPTH-1.
- busy_o  output  1  a block is being drained (state not IDLE).
- block_done_o  output  1  one-cycle pulse when the last word is accepted downstream.
- overrun_o  output  1  one-cycle pulse when a block-ready pulse is dropped.
- blocks_read_o  output  16  completed-block counter, wraps at 2^16.
- checksum_o  output  WIDTH  checksum of the last completed block.

## Operation
- Reset values: buf_ready_o=0, m_valid_o=0, m_data_o=0, m_first_o=0, m_last_o=0, busy_o=0, block_done_o=0, overrun_o=0, blocks_read_o=0, checksum_o=0; state IDLE; word counter 0.
- States:
  - IDLE -> DRAIN on buf_block_ready_i.
  - DRAIN -> TAIL once the upstream transfer count reaches DEPTH.
  - TAIL -> IDLE when the last word is accepted downstream.
  - TAIL -> DRAIN instead if buf_block_ready_i arrives in that same cycle.
- Upstream transfer: buf_valid_i && buf_ready_o.
- buf_ready_o = (state==DRAIN) && (!m_valid_o || m_ready_i).
- Each upstream transfer:
  - loads m_data_o;
  - sets m_first_o = (count==0) and m_last_o = (count==DEPTH-1);
  - increments count.
- Downstream transfer: m_valid_o && m_ready_i. The output stage holds its word while m_valid_o && !m_ready_i.
- m_valid_o clears after a downstream transfer that has no upstream transfer in the same cycle.
- Count resets to 0 on every entry into DRAIN.
- When the m_last_o word transfers downstream:
  - block_done_o pulses for one cycle;
  - blocks_read_o increments;
  - checksum_o updates (when enabled).
- buf_block_ready_i in DRAIN, or in TAIL without the final handshake:
  - overrun_o pulses for one cycle;
  - the pulse is otherwise ignored and the current block continues.
- buf_valid_i low in DRAIN inserts bubbles only; there is no timeout.

## Timing
- Latency: upstream transfer in cycle N -> m_valid_o high in cycle N+1.
- Throughput: one word per cycle while m_ready_i stays high.
- First buf_ready_o: the cycle after the buf_block_ready_i pulse.
- Back-to-back blocks:
  - a block-ready pulse in the final-handshake cycle gives buf_ready_o=1 on the next cycle;
  - block_done_o and the new block start coexist;
  - no overrun is reported.
- block_done_o is asserted the cycle after the final downstream handshake.
- Asynchronous reset mid-block:
  - all outputs go to their reset values immediately;
  - the in-flight word is dropped;
  - after release the reader waits in IDLE for a fresh pulse.
- Counter wrap: blocks_read_o goes 16'hFFFF -> 16'h0000 with no flag.

## Configuration
- RAM_BLOCK_READER_CHECKSUM_EN defined:
  - a WIDTH-bit running XOR of every upstream word in the block is kept;
  - it is cleared on DRAIN entry;
  - it is copied to checksum_o in the block_done_o cycle;
  - checksum_o holds until the next completion.
- Not defined: checksum_o is constant 0 and no accumulator logic is instantiated.

## Test plan
- Reset then single block:
  - WIDTH=32, DEPTH=4, words 1,2,3,4, m_ready_i=1.
  - Required: m_data_o 1..4 on consecutive cycles; m_first_o with 1, m_last_o with 4; block_done_o one pulse; blocks_read_o=1; checksum_o=4 (with EN).
- Downstream backpressure:
  - m_ready_i low for 3 cycles mid-block.
  - Required: m_data_o stable; buf_ready_o=0 during the stall; no word lost or duplicated.
- Overrun:
  - second buf_block_ready_i pulse at word 2 of 4.
  - Required: overrun_o one pulse; block completes with 4 words; busy_o falls afterwards; blocks_read_o=1.
- Back-to-back blocks:
  - block-ready pulse coincident with the final handshake.
  - Required: no overrun; next block's first word accepted the following cycle; blocks_read_o=2 after both.
- Upstream bubbles:
  - buf_valid_i toggling 1,0,1,0.
  - Required: exactly DEPTH words forwarded; m_last_o only on index DEPTH-1.
- Async reset:
  - rst_ni low mid-block at word 2.
  - Required: all outputs at reset values in the same cycle; a new block after release starts with m_first_o on its word 0.
